// File: rtl/ap_com_pkg.sv
// Shared types and constants for the approximate-compressor LUT array.
//   K_MAX        : largest supported LUT input count
//   ap_tt_t      : truth-table container sized for K_MAX inputs
//   ap_parity_tt : K-input parity table, used as the reset contents
//   AP_TT_IDX0   : truth table of the legacy fixed compressor cell 0
package ap_com_pkg;

  localparam int unsigned K_MAX = 4;

  typedef logic [2**K_MAX-1:0] ap_tt_t;

  localparam ap_tt_t AP_TT_IDX0 = 16'h44A0;

  // Bits at indices >= 2**k are left at zero.
  function automatic ap_tt_t ap_parity_tt(input int unsigned k);
    ap_tt_t tt;
    tt = '0;
    for (int unsigned j = 0; j < 2**K_MAX; j++) begin
      if (j < (32'd1 << k)) tt[j] = ^j;
    end
    return tt;
  endfunction

endpackage

// File: rtl/ap_com_lut_cell.sv
// One K-input LUT channel with a shadow/active truth-table pair.
//   clk, rst : clock, synchronous active-high reset (tables -> parity)
//   we, tt   : write tt into the shadow table
//   commit   : copy shadow into active; a same-cycle write is included
//   idx      : lookup index ({a,b,c,d}, a is the MSB)
//   lookup   : active[idx], combinational
module ap_com_lut_cell
  import ap_com_pkg::*;
#(
  parameter int unsigned K = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [2**K-1:0] tt,
  input  logic            commit,
  input  logic [K-1:0]    idx,
  output logic            lookup
);

  localparam int unsigned TT_W = 2**K;
  localparam ap_tt_t PARITY_FULL = ap_parity_tt(K);
  localparam logic [TT_W-1:0] PARITY = PARITY_FULL[TT_W-1:0];

  logic [TT_W-1:0] shadow;
  logic [TT_W-1:0] active;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= PARITY;
      active <= PARITY;
    end else begin
      if (we) shadow <= tt;
      // Write-through: a write landing with the commit is committed directly.
      if (commit) active <= we ? tt : shadow;
    end
  end

  assign lookup = active[idx];

endmodule

// File: rtl/ap_com_lut_array.sv
// Run-time programmable array of N_CH independent K-input LUT channels
// behind a one-stage registered valid/ready pipeline.
//   cfg_we/cfg_ch/cfg_tt : write a truth table into a channel's shadow table
//   cfg_commit           : atomically copy all shadow tables to active
//   in_valid/in_ready/in_data    : sample input, channel i at [i*K +: K]
//   out_valid/out_ready/out_data : registered lookup result, bit i = channel i
//   eval_cnt             : samples accepted since reset/commit, saturating
module ap_com_lut_array
  import ap_com_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned K     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [2**K-1:0]               cfg_tt,
  input  logic                          cfg_commit,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_CH*K-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_CH-1:0]               out_data,
  output logic [CNT_W-1:0]              eval_cnt
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            accept;
  logic            cfg_in_range;
  logic [N_CH-1:0] lookup;

  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign cfg_in_range = {1'b0, cfg_ch} < (CH_W + 1)'(N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ap_com_lut_cell #(
      .K (K)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .we     (cfg_we && cfg_in_range && (cfg_ch == CH_W'(i))),
      .tt     (cfg_tt),
      .commit (cfg_commit),
      .idx    (in_data[i*K +: K]),
      .lookup (lookup[i])
    );
  end

  // The cells' active tables update on the same edge that captures lookup,
  // so a sample accepted in the commit cycle still sees the old bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lookup;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eval_cnt <= '0;
    end else if (cfg_commit) begin
      eval_cnt <= accept ? CNT_W'(1) : '0;
    end else if (accept && (eval_cnt != '1)) begin
      eval_cnt <= eval_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ap_com_lut_array.sv
// Scoreboard bench for ap_com_lut_array (N_CH=6, K=4, CNT_W=4 build).
module tb_ap_com_lut_array;
  import ap_com_pkg::*;

  localparam int unsigned N_CH  = 6;
  localparam int unsigned K     = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = N_CH * K;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [2:0]      cfg_ch;
  logic [15:0]     cfg_tt;
  logic            cfg_commit;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N_CH-1:0] out_data;
  logic [CNT_W-1:0] eval_cnt;

  int checks = 0;
  int errors = 0;
  logic [N_CH-1:0] exp_q[$];
  logic [N_CH-1:0] mon_exp;

  ap_com_lut_array #(
    .N_CH  (N_CH),
    .K     (K),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_tt     (cfg_tt),
    .cfg_commit (cfg_commit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .eval_cnt   (eval_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [15:0] tt, input logic commit);
    cfg_we = 1'b1; cfg_ch = ch; cfg_tt = tt; cfg_commit = commit;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  // Drives one sample, waits (bounded) for in_ready, records the expectation.
  task automatic send(input logic [DW-1:0] d, input logic [N_CH-1:0] req);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(req);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    cfg_commit = 1'b0;
  endtask

  // Monitor: compares every output transfer against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%0h required=none", out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_tt = '0; cfg_commit = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_eval_cnt", 32'(eval_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: parity after reset
    send(24'h000175, 6'b000110);
    chk("t1_eval_cnt", 32'(eval_cnt), 32'd1);
    chk("t1_out_valid", 32'(out_valid), 32'd1);

    // 2: shadow write is invisible until commit
    cfg_write(3'd0, AP_TT_IDX0, 1'b0);
    send(24'h000005, 6'b000000);
    idle(1);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("t2_eval_after_commit", 32'(eval_cnt), 32'd0);
    send(24'h000005, 6'b000001);
    send(24'h00000A, 6'b000001);
    chk("t2_eval_cnt", 32'(eval_cnt), 32'd2);
    send(24'h000006, 6'b000000);
    idle(1);

    // 3: commit and accept in the same cycle
    do_reset();
    cfg_write(3'd0, AP_TT_IDX0, 1'b0);
    cfg_commit = 1'b1;
    send(24'h000005, 6'b000000);
    chk("t3_eval_cnt", 32'(eval_cnt), 32'd1);
    send(24'h000005, 6'b000001);

    // 4: backpressure
    send(24'h000005, 6'b000001);
    chk("t4_eval_before", 32'(eval_cnt), 32'd3);
    out_ready = 1'b0;
    in_data   = 24'h000130;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_out_data_hold", 32'(out_data), 32'd1);
      chk("t4_eval_hold", 32'(eval_cnt), 32'd3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(6'b000100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_eval_after", 32'(eval_cnt), 32'd4);
    idle(1);

    // 5: out-of-range channel writes are ignored
    cfg_write(3'd6, 16'h0000, 1'b1);
    cfg_write(3'd7, 16'h0000, 1'b0);
    chk("t5_eval_after_commit", 32'(eval_cnt), 32'd0);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    send(24'h777775, 6'b111111);
    send(24'h1248F5, 6'b111101);
    send(24'h000000, 6'b000000);
    idle(1);

    // 6: saturation and reset mid-stream
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) send(24'h000001, 6'b000001);
      else            send(24'h000003, 6'b000000);
      chk("t6_eval_cnt", 32'(eval_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    out_ready = 1'b0;
    chk("t6_valid_before_rst", 32'(out_valid), 32'd1);
    do_reset();
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_eval_cnt", 32'(eval_cnt), 32'd0);
    out_ready = 1'b1;
    send(24'h1248F5, 6'b111100);
    idle(3);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
